// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end for the pipelined RV32 core. Prefetches
// sequential instructions over the busywait instruction-memory protocol into a
// DEPTH-entry queue, which decode consumes with a valid/ready handshake. A
// taken branch/jump from EX flushes the queue and any in-flight fetch.
//
// Parameters
//   XLEN          address / instruction width
//   DEPTH         queue entries (power of two, >= 2)
//   RESET_VECTOR  first fetch address after reset
//
// Ports
//   CLK                  in   clock, all state updates on posedge
//   RESET                in   synchronous, active-low reset
//   INSTR_MEM_READ       out  fetch request
//   INSTR_MEM_ADDR       out  fetch address (stable while BUSYWAIT=1)
//   INSTR_MEM_READ_DATA  in   fetched word, valid when READ=1 && BUSYWAIT=0
//   INSTR_MEM_BUSYWAIT   in   memory not ready
//   REDIRECT             in   branch/jump taken
//   REDIRECT_TARGET      in   new PC
//   ID_READY             in   decode accepts the head entry
//   FETCH_VALID          out  head entry valid
//   FETCH_PC             out  PC of head entry
//   FETCH_INSTRUCTION    out  instruction of head entry
//   QUEUE_COUNT          out  occupied entries
//
// Optional feature (macro FETCH_PERF_COUNTERS_EN):
//   FETCH_BUSY_CYCLES    out  cycles with READ=1 && BUSYWAIT=1 (saturating)
//   FETCH_FLUSH_COUNT    out  REDIRECT cycles (saturating)
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  output logic                     INSTR_MEM_READ,
  output logic [XLEN-1:0]          INSTR_MEM_ADDR,
  input  logic [XLEN-1:0]          INSTR_MEM_READ_DATA,
  input  logic                     INSTR_MEM_BUSYWAIT,
  input  logic                     REDIRECT,
  input  logic [XLEN-1:0]          REDIRECT_TARGET,
  input  logic                     ID_READY,
  output logic                     FETCH_VALID,
  output logic [XLEN-1:0]          FETCH_PC,
  output logic [XLEN-1:0]          FETCH_INSTRUCTION,
  output logic [$clog2(DEPTH):0]   QUEUE_COUNT
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]              FETCH_BUSY_CYCLES,
  output logic [15:0]              FETCH_FLUSH_COUNT
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FETCH: normal prefetching. DISCARD: a request was in flight when a
  // redirect arrived; wait for it to complete and drop the returned word.
  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   pending_pc_q, pending_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [XLEN-1:0]   instr_mem_q [DEPTH];

  logic queue_full;
  logic queue_empty;
  logic req;
  logic accept;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign queue_empty = (count_q == '0);

  // RESET gates the request combinationally so READ drops in the very cycle
  // reset is asserted, not one edge later.
  assign req = RESET && (((state_q == ST_FETCH) && !queue_full) ||
                         (state_q == ST_DISCARD));

  assign accept = req && !INSTR_MEM_BUSYWAIT;

  // A redirect cycle discards both the push and the pop: the queue is flushed.
  assign push = accept && (state_q == ST_FETCH) && !REDIRECT;
  assign pop  = !queue_empty && ID_READY && !REDIRECT;

  // ---------------------------------------------------------------------------
  // Control: fetch PC, pending redirect target, state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets its default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;

    case (state_q)
      ST_FETCH: begin
        if (REDIRECT) begin
          if (req && INSTR_MEM_BUSYWAIT) begin
            // The address must stay stable until memory answers, so park the
            // target and throw away the in-flight word when it arrives.
            pending_pc_d = REDIRECT_TARGET;
            state_d      = ST_DISCARD;
          end else begin
            fetch_pc_d = REDIRECT_TARGET;
          end
        end else if (accept) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end

      ST_DISCARD: begin
        if (REDIRECT) begin
          pending_pc_d = REDIRECT_TARGET;
        end
        if (accept) begin
          // A redirect in the exit cycle is newer than the parked target.
          fetch_pc_d = REDIRECT ? REDIRECT_TARGET : pending_pc_q;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (REDIRECT) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= RESET_VECTOR;
      pending_pc_q <= RESET_VECTOR;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the storage array is cleared on reset so the head outputs read 0
  // rather than stale data; this keeps it out of plain RAM macros, which is
  // acceptable for a handful of entries.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= INSTR_MEM_READ_DATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign INSTR_MEM_READ    = req;
  assign INSTR_MEM_ADDR    = fetch_pc_q;
  assign FETCH_VALID       = !queue_empty;
  assign FETCH_PC          = pc_mem_q[rd_ptr_q];
  assign FETCH_INSTRUCTION = instr_mem_q[rd_ptr_q];
  assign QUEUE_COUNT       = count_q;

`ifdef FETCH_PERF_COUNTERS_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] busy_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      busy_cycles_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (req && INSTR_MEM_BUSYWAIT && (busy_cycles_q != '1)) begin
        busy_cycles_q <= busy_cycles_q + 32'd1;
      end
      if (REDIRECT && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign FETCH_BUSY_CYCLES = busy_cycles_q;
  assign FETCH_FLUSH_COUNT = flush_count_q;
`endif

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end that replaces the bare PC register plus PC+4/branch muxes in the pipelined RV32 core. It runs ahead of decode, prefetching sequential instructions from instruction memory over the busywait protocol into a DEPTH-entry queue. Decode consumes the queue with a valid/ready handshake. A branch/jump redirect from EX flushes the queue and any in-flight fetch.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: queue entries. Power of two, ≥2.
- RESET_VECTOR, 32'h0: first fetch address after reset.

- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset.
- INSTR_MEM_READ  out  1  fetch request.
- INSTR_MEM_ADDR  out  XLEN  fetch address.
- INSTR_MEM_READ_DATA  in  XLEN  fetched word; valid in any cycle with READ=1 and BUSYWAIT=0.
- INSTR_MEM_BUSYWAIT  in  1  memory not ready.
- REDIRECT  in  1  branch/jump taken (EX_BJ_SIG).
- REDIRECT_TARGET  in  XLEN  new PC (EX_ALU_OUT).
- ID_READY  in  1  decode accepts head entry (low on load-use hold).
- FETCH_VALID  out  1  head entry valid.
- FETCH_PC  out  XLEN  PC of head entry.
- FETCH_INSTRUCTION  out  XLEN  instruction of head entry.
- QUEUE_COUNT  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Registers:
  - fetch_pc
  - pending_pc
  - state ∈ {FETCH, DISCARD}
  - queue storage (PC, instruction) with rd_ptr, wr_ptr, count.
- Reset (RESET=0 at posedge):
  - fetch_pc=RESET_VECTOR, state=FETCH, pointers=0, count=0, storage=0.
  - While RESET=0, INSTR_MEM_READ is forced 0 combinationally.
- INSTR_MEM_READ = RESET && ((state==FETCH && count<DEPTH) || state==DISCARD).
- INSTR_MEM_ADDR = fetch_pc. It is held stable while BUSYWAIT=1.
- Accept: READ=1 && BUSYWAIT=0.
  - FETCH, no REDIRECT: push {fetch_pc, READ_DATA}; fetch_pc += 4.
- Pop: FETCH_VALID && ID_READY. rd_ptr advances.
- FETCH_VALID = (count!=0). FETCH_PC/FETCH_INSTRUCTION come combinationally from the head entry.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- REDIRECT in FETCH:
  - Queue flushed (count=0, rd_ptr=wr_ptr); any pop or push that cycle is discarded.
  - No request outstanding (READ=0), or accepted this cycle (BUSYWAIT=0): fetch_pc=REDIRECT_TARGET, stay FETCH.
  - READ=1 && BUSYWAIT=1: pending_pc=REDIRECT_TARGET, go to DISCARD.
- DISCARD:
  - READ stays 1 with the old address until BUSYWAIT=0.
  - That cycle the returned word is dropped, fetch_pc=pending_pc, state=FETCH.
  - A further REDIRECT in DISCARD only overwrites pending_pc. It also takes effect in the exit cycle; the newest target wins.
- Full: count==DEPTH leaves READ=0, so push while full cannot occur.

## Timing
- Zero-wait memory: REDIRECT at cycle t → READ with ADDR=target at t+1 → FETCH_VALID with FETCH_PC=target at t+2.
- Each BUSYWAIT cycle adds one cycle to that fetch.
- Sustained throughput: 1 instruction/cycle with zero-wait memory and ID_READY=1.
- First request after reset release: the cycle after the first posedge with RESET=1, ADDR=RESET_VECTOR.
- Reset mid-operation (including in DISCARD): all state returns to reset values at that edge; READ drops immediately.

## Configuration
- FETCH_PERF_COUNTERS_EN defined adds two outputs:
  - FETCH_BUSY_CYCLES (32): increments each cycle with READ=1 && BUSYWAIT=1.
  - FETCH_FLUSH_COUNT (16): increments on each REDIRECT cycle.
  - Both reset to 0 and saturate at all-ones.
- FETCH_PERF_COUNTERS_EN undefined: ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, zero-wait memory returning ADDR as data, ID_READY=1 → FETCH_PC 0,4,8,… one per cycle from the 2nd cycle after release; READ_DATA equals PC.
- ID_READY=0 with DEPTH=4 → QUEUE_COUNT reaches 4, READ drops. ID_READY=1 → entries drain in order 0,4,8,12, then fetching resumes at 16.
- REDIRECT to 0x100 while count=3 → next cycle FETCH_VALID=0, READ with ADDR=0x100; FETCH_PC=0x100 one cycle later.
- Request at 0x20 with BUSYWAIT=1 for 3 cycles, REDIRECT to 0x200 in the 1st of them → ADDR stays 0x20 until BUSYWAIT falls; that word is never presented; next ADDR=0x200.
- Redirect to 0x300 then 0x400 during DISCARD → next fetch address is 0x400.
- RESET=0 for one cycle while in DISCARD with count=2 → READ=0, count=0; next fetch at RESET_VECTOR. With FETCH_PERF_COUNTERS_EN, both counters read 0.
